// File: rtl/phase_sequencer.sv
// Round controller ahead of the shared address mux: launches the eight policy phases in order,
// waits for each phase's done (bounded by a watchdog) and steers the mux to the active phase.
module phase_sequencer #(
  parameter int NUM_PHASES = 8,
  parameter int SEL_W      = 3,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start_round,
  input  logic [NUM_PHASES-1:0] skip_mask,
  input  logic [NUM_PHASES-1:0] phase_done,
  output logic [NUM_PHASES-1:0] phase_start,
  output logic [SEL_W-1:0]      mux_sel,
  output logic                  busy,
  output logic                  round_done,
  output logic [CNT_W-1:0]      round_count,
  output logic                  timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_ADVANCE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                state_r;
  logic [SEL_W-1:0]      cur_phase_r;
  logic [NUM_PHASES-1:0] mask_r;
  logic [WD_W-1:0]       wdog_r;
  logic [CNT_W-1:0]      round_count_r;
  logic                  timeout_err_r;

  logic [SEL_W:0]        first_s;
  logic [SEL_W:0]        next_lo_s;
  logic [SEL_W:0]        next_s;
  logic                  done_hit_s;

  // Lowest phase index >= lo that is not masked; MSB of the result flags that one exists.
  function automatic logic [SEL_W:0] find_unmasked(input logic [NUM_PHASES-1:0] mask,
                                                   input logic [SEL_W:0]        lo);
    logic [SEL_W:0] res;
    res = {(SEL_W+1){1'b0}};
    for (int i = NUM_PHASES - 1; i >= 0; i--) begin
      if (((SEL_W+1)'(i) >= lo) && !mask[i]) begin
        res = {1'b1, SEL_W'(i)};
      end
    end
    return res;
  endfunction

  assign first_s    = find_unmasked(skip_mask, {(SEL_W+1){1'b0}});
  assign next_lo_s  = {1'b0, cur_phase_r} + (SEL_W+1)'(1);
  assign next_s     = find_unmasked(mask_r, next_lo_s);
  assign done_hit_s = phase_done[cur_phase_r];

  // Sequencer state, phase pointer, watchdog, round counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_IDLE;
      cur_phase_r   <= {SEL_W{1'b0}};
      mask_r        <= {NUM_PHASES{1'b0}};
      wdog_r        <= {WD_W{1'b0}};
      round_count_r <= {CNT_W{1'b0}};
      timeout_err_r <= 1'b0;
    end else if (en) begin
      case (state_r)
        S_IDLE: begin
          if (start_round) begin
            mask_r        <= skip_mask;
            timeout_err_r <= 1'b0;
            if (first_s[SEL_W]) begin
              cur_phase_r <= first_s[SEL_W-1:0];
              state_r     <= S_LAUNCH;
            end else begin
              state_r     <= S_DONE;
            end
          end
        end
        S_LAUNCH: begin
          wdog_r  <= {WD_W{1'b0}};
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving on the watchdog's last cycle still counts as success.
          if (done_hit_s) begin
            state_r <= S_ADVANCE;
          end else if (wdog_r == WD_LAST) begin
            timeout_err_r <= 1'b1;
            state_r       <= S_ADVANCE;
          end else begin
            wdog_r <= wdog_r + WD_W'(1);
          end
        end
        S_ADVANCE: begin
          if (next_s[SEL_W]) begin
            cur_phase_r <= next_s[SEL_W-1:0];
            state_r     <= S_LAUNCH;
          end else begin
            state_r     <= S_DONE;
          end
        end
        S_DONE: begin
          round_count_r <= round_count_r + CNT_W'(1);
          state_r       <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Pulses are gated by en so a frozen LAUNCH/DONE emits its pulse only once en returns.
  assign phase_start = (en && (state_r == S_LAUNCH)) ? (NUM_PHASES'(1) << cur_phase_r)
                                                     : {NUM_PHASES{1'b0}};
  assign round_done  = en && (state_r == S_DONE);
  assign mux_sel     = cur_phase_r;
  assign busy        = (state_r != S_IDLE);
  assign round_count = round_count_r;
  assign timeout_err = timeout_err_r;

endmodule
